// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with architectural flags, retired counter and sticky control-error bit.
// One-cycle latency; priority rst > flush > freeze > capture, freeze holds every register.
module exe_mem_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             s_in,
  input  logic [31:0]      alu_res_in,
  input  logic [31:0]      st_val_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       flags_in,
  output logic             valid_out,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [31:0]      alu_res,
  output logic [31:0]      st_val,
  output logic [3:0]       dest,
  output logic [3:0]       status,
  output logic [CNT_W-1:0] retired,
  output logic             ctrl_err
);

  logic             valid_q, valid_d;
  logic             wb_en_q, wb_en_d;
  logic             mem_r_en_q, mem_r_en_d;
  logic             mem_w_en_q, mem_w_en_d;
  logic [31:0]      alu_res_q, alu_res_d;
  logic [31:0]      st_val_q, st_val_d;
  logic [3:0]       dest_q, dest_d;
  logic [3:0]       status_q, status_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ctrl_err_q, ctrl_err_d;

  logic capture;
  assign capture = !flush && !freeze;

  always_comb begin
    valid_d    = valid_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    alu_res_d  = alu_res_q;
    st_val_d   = st_val_q;
    dest_d     = dest_q;
    status_d   = status_q;
    retired_d  = retired_q;
    ctrl_err_d = ctrl_err_q;

    if (flush) begin
      // Bubble: kill the slot's side effects but keep the data fields as they were.
      valid_d    = 1'b0;
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
      mem_w_en_d = 1'b0;
    end else if (capture) begin
      valid_d    = in_valid;
      wb_en_d    = in_valid & wb_en_in;
      mem_r_en_d = in_valid & mem_r_en_in;
      mem_w_en_d = in_valid & mem_w_en_in;
      alu_res_d  = alu_res_in;
      st_val_d   = st_val_in;
      dest_d     = dest_in;
      if (in_valid) begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (s_in) begin
          status_d = flags_in;
        end
        if (mem_r_en_in && mem_w_en_in) begin
          ctrl_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      status_q   <= '0;
      retired_q  <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      st_val_q   <= st_val_d;
      dest_q     <= dest_d;
      status_q   <= status_d;
      retired_q  <= retired_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  assign valid_out = valid_q;
  assign wb_en     = wb_en_q;
  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign alu_res   = alu_res_q;
  assign st_val    = st_val_q;
  assign dest      = dest_q;
  assign status    = status_q;
  assign retired   = retired_q;
  assign ctrl_err  = ctrl_err_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed-vector bench: stimulus pushes the hand-computed post-edge state, a monitor pops and compares.
module tb_exe_mem_reg;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic [3:0]  retired;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, freeze, flush, in_valid;
  logic             wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
  logic [31:0]      alu_res_in, st_val_in;
  logic [3:0]       dest_in, flags_in;
  logic             valid_out, wb_en, mem_r_en, mem_w_en, ctrl_err;
  logic [31:0]      alu_res, st_val;
  logic [3:0]       dest, status;
  logic [CNT_W-1:0] retired;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  exe_mem_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .s_in(s_in),
    .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in), .flags_in(flags_in),
    .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .st_val(st_val), .dest(dest), .status(status),
    .retired(retired), .ctrl_err(ctrl_err)
  );

  function automatic string fmt(input exp_t e);
    return $sformatf("v=%b wb=%b mr=%b mw=%b alu=%h st=%h dest=%h status=%b retired=%0d err=%b",
                     e.valid, e.wb, e.mr, e.mw, e.alu, e.st, e.dest, e.status, e.retired, e.err);
  endfunction

  // Inputs change on the falling edge; the pushed value is the state after the next rising edge.
  task automatic drive(input logic r, input logic fl, input logic fz, input logic iv,
                       input logic wb, input logic mr, input logic mw, input logic s,
                       input logic [31:0] alu, input logic [31:0] st,
                       input logic [3:0] dst, input logic [3:0] flg,
                       input exp_t e, input string nm);
    @(negedge clk);
    rst = r; flush = fl; freeze = fz; in_valid = iv;
    wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw; s_in = s;
    alu_res_in = alu; st_val_in = st; dest_in = dst; flags_in = flg;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  g, e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g.valid = valid_out; g.wb = wb_en; g.mr = mem_r_en; g.mw = mem_w_en;
        g.alu = alu_res; g.st = st_val; g.dest = dest; g.status = status;
        g.retired = retired; g.err = ctrl_err;
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s: got {%s} required {%s}", nm, fmt(g), fmt(e));
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   budget;
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; s_in = 1'b0;
    alu_res_in = '0; st_val_in = '0; dest_in = '0; flags_in = '0;

    e = '0;
    drive(1,0,0, 1,1,1,1,1, 32'hFFFF_FFFF, 32'h1111_1111, 4'hF, 4'hF, e, "reset_cap");
    drive(1,1,1, 1,1,0,0,1, 32'h2222_2222, 32'h3333_3333, 4'hE, 4'hA, e, "reset_held");

    // Basic capture
    e = '0; e.valid = 1; e.wb = 1; e.alu = 32'h5; e.dest = 4'd3; e.retired = 4'd1;
    drive(0,0,0, 1,1,0,0,0, 32'h5, 32'h0, 4'd3, 4'h0, e, "basic_capture");

    // S-bit gating
    e.alu = 32'h10; e.st = 32'hAA; e.dest = 4'd4; e.status = 4'b0110; e.retired = 4'd2;
    drive(0,0,0, 1,1,0,0,1, 32'h10, 32'hAA, 4'd4, 4'b0110, e, "s_set");
    e.mr = 1; e.alu = 32'h20; e.st = 32'h0; e.dest = 4'd5; e.retired = 4'd3;
    drive(0,0,0, 1,1,1,0,0, 32'h20, 32'h0, 4'd5, 4'b1001, e, "s_clear_holds");

    // Bubble: enables forced low, data loads, no status/counter/err update even with r&w high
    e.valid = 0; e.wb = 0; e.mr = 0; e.mw = 0; e.alu = 32'h30; e.st = 32'h33; e.dest = 4'd6;
    drive(0,0,0, 0,1,1,1,1, 32'h30, 32'h33, 4'd6, 4'b1111, e, "bubble_capture");

    e.valid = 1; e.wb = 1; e.alu = 32'hDEAD_BEEF; e.st = 32'h1234_5678; e.dest = 4'd7;
    e.status = 4'b0011; e.retired = 4'd4;
    drive(0,0,0, 1,1,0,0,1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd7, 4'b0011, e, "capture_s2");

    // Freeze holds everything while inputs change
    drive(0,0,1, 1,0,1,1,1, 32'hA1, 32'hB1, 4'd9, 4'b1111, e, "freeze1");
    drive(0,0,1, 0,1,1,0,0, 32'hA2, 32'hB2, 4'd10, 4'b0001, e, "freeze2");
    drive(0,0,1, 1,1,0,1,1, 32'hA3, 32'hB3, 4'd11, 4'b1000, e, "freeze3");

    // Flush wins over freeze; data and status/retired stay
    e.valid = 0; e.wb = 0;
    drive(0,1,1, 1,1,1,1,1, 32'h99, 32'h98, 4'd12, 4'b1100, e, "flush_freeze");
    drive(0,1,0, 1,1,0,0,1, 32'h77, 32'h76, 4'd13, 4'b0101, e, "flush_only");

    // Control error: both enables registered, sticky bit set
    e.valid = 1; e.wb = 0; e.mr = 1; e.mw = 1; e.alu = 32'h100; e.st = 32'h200; e.dest = 4'd8;
    e.retired = 4'd5; e.err = 1;
    drive(0,0,0, 1,0,1,1,0, 32'h100, 32'h200, 4'd8, 4'b1111, e, "ctrl_err_set");
    for (int i = 0; i < 5; i++) begin
      e.wb = 1; e.mr = 0; e.mw = 0; e.alu = 32'h40 + i; e.st = 32'h0; e.dest = 4'(i);
      e.retired = 4'(6 + i);
      drive(0,0,0, 1,1,0,0,0, 32'h40 + i, 32'h0, 4'(i), 4'b1111, e, $sformatf("err_sticky%0d", i));
    end

    // Reset with flush and an S capture present: everything clears
    e = '0;
    drive(1,1,0, 1,1,0,1,1, 32'h5555, 32'h6666, 4'd2, 4'b1010, e, "rst_over_all");

    // 17 valid captures on a 4-bit counter end at 1
    for (int i = 1; i <= 17; i++) begin
      e.valid = 1; e.wb = 1; e.alu = i; e.dest = 4'(i); e.retired = 4'(i % 16);
      drive(0,0,0, 1,1,0,0,0, i, 32'h0, 4'(i), 4'h0, e, $sformatf("wrap%0d", i));
    end

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
